// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and helpers for the FP write-back path
package fp_pkg;

  localparam int FLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  // Grant encoding used by the round-robin pointer
  localparam logic SRC_FPU = 1'b0;
  localparam logic SRC_LD  = 1'b1;

  // Single-precision values live in the low half with all-ones above
  function automatic logic [FLEN-1:0] nanbox(input logic [FLEN-1:0] data,
                                             input logic            single);
    return single ? {NANBOX_HI, data[31:0]} : data;
  endfunction

endpackage

// File: rtl/fp_writeback_arbiter_if.sv
// rtl/fp_writeback_arbiter_if.sv - producer, issue and register-file signals of the write-back arbiter
interface fp_writeback_arbiter_if;
  import fp_pkg::*;

  logic            fpu_valid;
  logic            fpu_ready;
  logic [AW-1:0]   fpu_rd;
  logic [FLEN-1:0] fpu_data;
  logic            fpu_single;

  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [FLEN-1:0] ld_data;
  logic            ld_single;

  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            flush;

  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [FLEN-1:0] rf_wd;
  logic [NREG-1:0] pending;

  // Arbiter side
  modport master (
    input  fpu_valid, fpu_rd, fpu_data, fpu_single,
    input  ld_valid, ld_rd, ld_data, ld_single,
    input  issue_valid, issue_rd, flush,
    output fpu_ready, ld_ready,
    output rf_we, rf_wa, rf_wd, pending
  );

  // Producers, issue logic and register file side
  modport slave (
    output fpu_valid, fpu_rd, fpu_data, fpu_single,
    output ld_valid, ld_rd, ld_data, ld_single,
    output issue_valid, issue_rd, flush,
    input  fpu_ready, ld_ready,
    input  rf_we, rf_wa, rf_wd, pending
  );

endinterface

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - pending-write mask with flush > set > clear priority
module fp_scoreboard
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_rd,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_rd,
  input  logic            flush,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_nxt;

  // Clear first so a same-cycle set of a newer producer wins; flush overrides everything
  always_comb begin
    pending_nxt = pending;
    if (clr_en && clr_rd != '0) pending_nxt[clr_rd] = 1'b0;
    if (set_en && set_rd != '0) pending_nxt[set_rd] = 1'b1;
    if (flush)                  pending_nxt = '0;
  end

  // Mask register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// rtl/fp_writeback_arbiter.sv - merges FPU and FP-load results onto the FP register file write port
module fp_writeback_arbiter
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_writeback_arbiter_if.master bus
);

  logic            last_grant;
  logic            grant;
  logic            granted;
  logic [AW-1:0]   sel_rd;
  logic [FLEN-1:0] sel_data;
  logic            we_q;
  logic [AW-1:0]   wa_q;
  logic [FLEN-1:0] wd_q;
  logic [NREG-1:0] pending_q;

  // Round-robin choice: under contention the source not served last time wins
  always_comb begin
    granted = bus.fpu_valid | bus.ld_valid;
    if (bus.fpu_valid && bus.ld_valid) grant = ~last_grant;
    else if (bus.fpu_valid)            grant = SRC_FPU;
    else                               grant = SRC_LD;
    if (grant == SRC_FPU) begin
      sel_rd   = bus.fpu_rd;
      sel_data = nanbox(bus.fpu_data, bus.fpu_single);
    end else begin
      sel_rd   = bus.ld_rd;
      sel_data = nanbox(bus.ld_data, bus.ld_single);
    end
  end

  assign bus.fpu_ready = bus.fpu_valid && (grant == SRC_FPU);
  assign bus.ld_ready  = bus.ld_valid  && (grant == SRC_LD);

  // Registered write port; f0 transfers are accepted but never write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      last_grant <= SRC_LD;
    end else begin
      we_q <= granted && (sel_rd != '0);
      if (granted) begin
        wa_q       <= sel_rd;
        wd_q       <= sel_data;
        last_grant <= grant;
      end
    end
  end

  assign bus.rf_we = we_q;
  assign bus.rf_wa = wa_q;
  assign bus.rf_wd = wd_q;

  fp_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.issue_valid),
    .set_rd  (bus.issue_rd),
    .clr_en  (granted),
    .clr_rd  (sel_rd),
    .flush   (bus.flush),
    .pending (pending_q)
  );

  assign bus.pending = pending_q;

endmodule

// File: doc/fp_writeback_arbiter.md
Name: fp_writeback_arbiter

Overview:
Write-side master for the 32 x 64-bit FP register file. It merges results from the FPU pipeline and from FP loads (FLW/FLD) onto the register file's single write port. It NaN-boxes single-precision values. It also keeps a pending-write scoreboard that issue logic uses for RAW/WAW stalls.

Parameters:
FLEN, 64, FP register / data width
NREG, 32, number of FP registers
AW, 5, register address width (log2 NREG)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
fpu_valid  in  1  FPU result valid
fpu_ready  out  1  FPU result accepted this cycle
fpu_rd  in  AW  FPU destination register
fpu_data  in  FLEN  FPU result
fpu_single  in  1  1 = result is 32-bit single; NaN-box it
ld_valid  in  1  FP load data valid
ld_ready  out  1  load data accepted this cycle
ld_rd  in  AW  load destination register
ld_data  in  FLEN  load data (single in bits [31:0])
ld_single  in  1  1 = FLW; NaN-box it
issue_valid  in  1  FP-writing instruction issued this cycle
issue_rd  in  AW  its destination register
flush  in  1  pipeline flush; clears the scoreboard
rf_we  out  1  register file write enable (to WE3)
rf_wa  out  AW  register file write address (to A3)
rf_wd  out  FLEN  register file write data (to WD3)
pending  out  NREG  bit i = write to f[i] outstanding

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low. On reset:
  - rf_we=0, rf_wa=0, rf_wd=0
  - pending=0
  - round-robin pointer last_grant=LD, so the FPU wins the first contention
- Ready signals are combinational:
  - fpu_ready = fpu_valid && grant==FPU
  - ld_ready = ld_valid && grant==LD
  - At most one source is ready per cycle.
- Arbitration:
  - Only one source valid -> that source is granted.
  - Both valid -> grant the source that is not last_grant.
  - last_grant updates only on an actual grant.
  - No source is ever starved for more than 1 cycle.
- Data formatting:
  - single=1 -> data = {32'hFFFF_FFFF, src_data[31:0]}; upper input bits are ignored.
  - single=0 -> data passes through unchanged.
- Write register (1-cycle latency):
  - Grant in cycle N -> rf_we=1, rf_wa=rd, rf_wd=formatted data in cycle N+1.
  - No grant -> rf_we=0; rf_wa and rf_wd hold their previous values.
- rd==0:
  - The transfer is still accepted (ready=1).
  - rf_we stays 0 because the register file ignores address 0.
  - pending[0] is never set.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd] at the clock edge.
  - A grant with rd!=0 clears pending[rd] at the same edge the write is registered.
  - Set and clear of the same rd in the same cycle -> set wins (a newer producer is outstanding).
  - Setting an already-pending bit leaves it 1. WAW ordering is issue logic's job.
- Flush:
  - flush=1 clears all pending bits at the next edge, overriding any set in that cycle.
  - A grant in the flush cycle still writes the register file.
  - Valid/ready handshakes are not cancelled; producers drop their own work.
- Reset mid-operation: all state returns to reset values immediately (async). Any in-flight rf_we pulse is cancelled.

Decomposition:
- Shared package fp_pkg holds:
  - FLEN, NREG, AW
  - NANBOX_HI = 32'hFFFF_FFFF
  - grant encoding localparams SRC_FPU=1'b0, SRC_LD=1'b1
- One natural sub-module: fp_scoreboard (pending mask with set/clear/flush priority).
- Arbitration and formatting stay inline.

Test Plan:
- Reset then idle -> rf_we=0, pending=0, both readies 0.
- FPU only: fpu_valid, rd=3, data=64'h4009_21FB_5444_2D18, single=0 -> fpu_ready=1; next cycle rf_we=1, rf_wa=3, rf_wd=same data.
- FLW NaN-box: ld_valid, rd=7, data=64'h1234_5678_3F80_0000, single=1 -> next cycle rf_wd=64'hFFFF_FFFF_3F80_0000.
- Contention over 4 cycles, both valid every cycle -> grants go FPU, LD, FPU, LD; writes appear one cycle after each grant.
- Scoreboard: issue rd=5 -> pending[5]=1. Then issue rd=5 in the same cycle as the FPU write to rd=5 -> pending[5] stays 1. A later write to rd=5 with no issue -> pending[5]=0.
- rd=0 write plus flush with pending=32'h0000_00A0 -> ready=1, rf_we=0, pending=0 next cycle. Assert rst mid-write -> rf_we drops immediately.
